// File: rtl/voice_alloc_if.sv
// Event/voice-bank bundle between midi_ctrl, voice_alloc and the synth voice bank.
// master = event source and voice-bank side, slave = voice_alloc.
interface voice_alloc_if #(
    parameter int NUM_VOICES = 8
);
    logic                    note_pressed;
    logic                    note_released;
    logic [6:0]              note;
    logic [6:0]              velocity;
    logic [3:0]              channel;
    logic [NUM_VOICES-1:0]   voice_active;
    logic [NUM_VOICES-1:0]   voice_gate;
    logic [NUM_VOICES-1:0]   voice_start;
    logic [NUM_VOICES-1:0]   voice_stop;
    logic [7*NUM_VOICES-1:0] voice_note;
    logic [7*NUM_VOICES-1:0] voice_vel;
    logic [4*NUM_VOICES-1:0] voice_chan;
    logic                    busy;
    logic [7:0]              ev_drop;
    logic [7:0]              steal_cnt;

    modport master (
        output note_pressed, note_released, note, velocity, channel, voice_active,
        input  voice_gate, voice_start, voice_stop, voice_note, voice_vel, voice_chan,
        input  busy, ev_drop, steal_cnt
    );

    modport slave (
        input  note_pressed, note_released, note, velocity, channel, voice_active,
        output voice_gate, voice_start, voice_stop, voice_note, voice_vel, voice_chan,
        output busy, ev_drop, steal_cnt
    );
endinterface

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: queues note events and maps them onto NUM_VOICES voices.
// Optional macro VOICE_STEAL_EN: steal the oldest gated voice when no other voice is free.
module voice_alloc #(
    parameter int NUM_VOICES = 8,
    parameter int EVQ_DEPTH  = 4,
    parameter int AGE_W      = 8
) (
    input  logic         clk32,
    input  logic         nreset,
    voice_alloc_if.slave bus
);
    localparam int VI_W  = $clog2(NUM_VOICES);
    localparam int PTR_W = $clog2(EVQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SCAN = 2'd1, ST_COMMIT = 2'd2} state_t;
    typedef struct packed {
        logic       press;
        logic [6:0] note;
        logic [6:0] vel;
        logic [3:0] chan;
    } ev_t;

    state_t                state_r, state_nx_s;
    ev_t                   fifo_r [EVQ_DEPTH];
    ev_t                   wr_ev_s, ev_r;
    logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]      cnt_r, cnt_nx_s;
    logic                  wr_req_s, wr_ok_s, pop_s;
    logic [1:0]            drop_inc_s;
    logic [8:0]            drop_sum_s;
    logic [7:0]            ev_drop_r, steal_cnt_r;
    logic                  busy_r;

    logic [VI_W-1:0]       scan_idx_r;
    logic                  ret_hit_r, free_hit_r, old_hit_r, stl_hit_r;
    logic [VI_W-1:0]       ret_idx_r, free_idx_r, old_idx_r, stl_idx_r;
    logic [AGE_W-1:0]      old_age_r, stl_age_r;
    logic                  cur_gate_s, cur_act_s, cur_match_s;
    logic [AGE_W-1:0]      cur_age_s;
    logic                  sel_hit_s, sel_steal_s, fail_s;
    logic [VI_W-1:0]       sel_idx_s;

    logic [NUM_VOICES-1:0] gate_r, start_r, stop_r;
    logic [6:0]            note_r [NUM_VOICES];
    logic [6:0]            vel_r  [NUM_VOICES];
    logic [3:0]            chan_r [NUM_VOICES];
    logic [AGE_W-1:0]      age_r  [NUM_VOICES];
    logic [7*NUM_VOICES-1:0] note_pk_s, vel_pk_s;
    logic [4*NUM_VOICES-1:0] chan_pk_s;

    // Event capture: a zero-velocity press is a release; a press beats a simultaneous release.
    always_comb begin
        wr_req_s      = bus.note_pressed | bus.note_released;
        wr_ev_s.press = bus.note_pressed & (bus.velocity != 7'd0);
        wr_ev_s.note  = bus.note;
        wr_ev_s.vel   = bus.velocity;
        wr_ev_s.chan  = bus.channel;
        pop_s         = (state_r == ST_IDLE) && (cnt_r != {CNT_W{1'b0}});
        wr_ok_s       = wr_req_s && ((cnt_r != CNT_W'(EVQ_DEPTH)) || pop_s);
        drop_inc_s    = {1'b0, bus.note_pressed & bus.note_released} + {1'b0, wr_req_s & ~wr_ok_s};
        drop_sum_s    = {1'b0, ev_drop_r} + {7'd0, drop_inc_s};
        cnt_nx_s      = cnt_r + {{(CNT_W-1){1'b0}}, wr_ok_s} - {{(CNT_W-1){1'b0}}, pop_s};
    end

    // Event FIFO storage and pointers.
    always_ff @(posedge clk32 or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < EVQ_DEPTH; i++) fifo_r[i] <= '{1'b0, 7'd0, 7'd0, 4'd0};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            if (wr_ok_s) begin
                fifo_r[wr_ptr_r] <= wr_ev_s;
                wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            cnt_r <= cnt_nx_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk32 or negedge nreset) begin
        if (!nreset) state_r <= ST_IDLE;
        else         state_r <= state_nx_s;
    end

    // FSM next state: one pop, NUM_VOICES scan cycles, one commit cycle.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE:   if (pop_s) state_nx_s = ST_SCAN; else state_nx_s = ST_IDLE;
            ST_SCAN:   if (scan_idx_r == VI_W'(NUM_VOICES - 1)) state_nx_s = ST_COMMIT;
                       else state_nx_s = ST_SCAN;
            ST_COMMIT: state_nx_s = ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // Current scan voice attributes.
    always_comb begin
        cur_gate_s  = gate_r[scan_idx_r];
        cur_act_s   = bus.voice_active[scan_idx_r];
        cur_age_s   = age_r[scan_idx_r];
        cur_match_s = cur_gate_s && (note_r[scan_idx_r] == ev_r.note) && (chan_r[scan_idx_r] == ev_r.chan);
    end

    // Head event latch and candidate tracking; strict '>' keeps the lowest index on age ties.
    always_ff @(posedge clk32 or negedge nreset) begin
        if (!nreset) begin
            ev_r       <= '{1'b0, 7'd0, 7'd0, 4'd0};
            scan_idx_r <= {VI_W{1'b0}};
            {ret_hit_r, free_hit_r, old_hit_r, stl_hit_r} <= 4'd0;
            {ret_idx_r, free_idx_r, old_idx_r, stl_idx_r} <= {(4*VI_W){1'b0}};
            old_age_r  <= {AGE_W{1'b0}};
            stl_age_r  <= {AGE_W{1'b0}};
        end else if (pop_s) begin
            ev_r       <= fifo_r[rd_ptr_r];
            scan_idx_r <= {VI_W{1'b0}};
            {ret_hit_r, free_hit_r, old_hit_r, stl_hit_r} <= 4'd0;
            old_age_r  <= {AGE_W{1'b0}};
            stl_age_r  <= {AGE_W{1'b0}};
        end else if (state_r == ST_SCAN) begin
            scan_idx_r <= scan_idx_r + VI_W'(1);
            if (cur_match_s && !ret_hit_r) begin
                ret_hit_r <= 1'b1;
                ret_idx_r <= scan_idx_r;
            end
            if (!cur_gate_s && !cur_act_s && !free_hit_r) begin
                free_hit_r <= 1'b1;
                free_idx_r <= scan_idx_r;
            end
            if (!cur_gate_s && (!old_hit_r || (cur_age_s > old_age_r))) begin
                old_hit_r <= 1'b1;
                old_idx_r <= scan_idx_r;
                old_age_r <= cur_age_s;
            end
            if (cur_gate_s && (!stl_hit_r || (cur_age_s > stl_age_r))) begin
                stl_hit_r <= 1'b1;
                stl_idx_r <= scan_idx_r;
                stl_age_r <= cur_age_s;
            end
        end
    end

    // Commit selection: retrigger, free, oldest released, then steal or fail.
    always_comb begin
        sel_hit_s   = 1'b0;
        sel_idx_s   = {VI_W{1'b0}};
        sel_steal_s = 1'b0;
        fail_s      = 1'b0;
        if (state_r != ST_COMMIT) begin
            sel_hit_s = 1'b0;
        end else if (!ev_r.press) begin
            sel_hit_s = ret_hit_r;
            sel_idx_s = ret_idx_r;
        end else if (ret_hit_r) begin
            sel_hit_s = 1'b1;
            sel_idx_s = ret_idx_r;
        end else if (free_hit_r) begin
            sel_hit_s = 1'b1;
            sel_idx_s = free_idx_r;
        end else if (old_hit_r) begin
            sel_hit_s = 1'b1;
            sel_idx_s = old_idx_r;
        end else begin
`ifdef VOICE_STEAL_EN
            sel_hit_s   = stl_hit_r;
            sel_idx_s   = stl_idx_r;
            sel_steal_s = stl_hit_r;
            fail_s      = ~stl_hit_r;
`else
            fail_s      = 1'b1;
`endif
        end
    end

    // Voice state, ages and one-cycle start/stop pulses.
    always_ff @(posedge clk32 or negedge nreset) begin
        if (!nreset) begin
            gate_r  <= {NUM_VOICES{1'b0}};
            start_r <= {NUM_VOICES{1'b0}};
            stop_r  <= {NUM_VOICES{1'b0}};
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_r[i] <= 7'd0;
                vel_r[i]  <= 7'd0;
                chan_r[i] <= 4'd0;
                age_r[i]  <= {AGE_W{1'b0}};
            end
        end else begin
            start_r <= {NUM_VOICES{1'b0}};
            stop_r  <= {NUM_VOICES{1'b0}};
            if (sel_hit_s && ev_r.press) begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (sel_idx_s == VI_W'(i)) begin
                        gate_r[i]  <= 1'b1;
                        note_r[i]  <= ev_r.note;
                        vel_r[i]   <= ev_r.vel;
                        chan_r[i]  <= ev_r.chan;
                        age_r[i]   <= {AGE_W{1'b0}};
                        start_r[i] <= 1'b1;
                        stop_r[i]  <= sel_steal_s;
                    end else if (age_r[i] != AGE_MAX) begin
                        age_r[i] <= age_r[i] + AGE_W'(1);
                    end
                end
            end else if (sel_hit_s) begin
                gate_r[sel_idx_s] <= 1'b0;
                stop_r[sel_idx_s] <= 1'b1;
            end
        end
    end

    // Saturating status counters and busy flag.
    always_ff @(posedge clk32 or negedge nreset) begin
        if (!nreset) begin
            ev_drop_r   <= 8'd0;
            steal_cnt_r <= 8'd0;
            busy_r      <= 1'b0;
        end else begin
            ev_drop_r <= drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
            if ((sel_steal_s || fail_s) && (steal_cnt_r != 8'hFF)) steal_cnt_r <= steal_cnt_r + 8'd1;
            busy_r <= (state_nx_s != ST_IDLE) || (cnt_nx_s != {CNT_W{1'b0}});
        end
    end

    // Pack per-voice registers onto the flat output buses.
    always_comb begin
        note_pk_s = {(7*NUM_VOICES){1'b0}};
        vel_pk_s  = {(7*NUM_VOICES){1'b0}};
        chan_pk_s = {(4*NUM_VOICES){1'b0}};
        for (int i = 0; i < NUM_VOICES; i++) begin
            note_pk_s[7*i +: 7] = note_r[i];
            vel_pk_s[7*i +: 7]  = vel_r[i];
            chan_pk_s[4*i +: 4] = chan_r[i];
        end
    end

    assign bus.voice_gate  = gate_r;
    assign bus.voice_start = start_r;
    assign bus.voice_stop  = stop_r;
    assign bus.voice_note  = note_pk_s;
    assign bus.voice_vel   = vel_pk_s;
    assign bus.voice_chan  = chan_pk_s;
    assign bus.busy        = busy_r;
    assign bus.ev_drop     = ev_drop_r;
    assign bus.steal_cnt   = steal_cnt_r;
endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc (8 voices, 4-deep queue); expected values hand-computed.
module tb_voice_alloc;
    logic clk32;
    logic nreset;
    int   n_vec;
    int   n_bad;

    voice_alloc_if #(.NUM_VOICES(8)) ifc ();

    voice_alloc #(.NUM_VOICES(8), .EVQ_DEPTH(4), .AGE_W(8)) dut (
        .clk32  (clk32),
        .nreset (nreset),
        .bus    (ifc)
    );

    initial begin
        clk32 = 1'b0;
        forever #5 clk32 = ~clk32;
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk32);
        #1;
    endtask

    task automatic send(input logic p, input logic r, input logic [6:0] n,
                        input logic [6:0] v, input logic [3:0] c);
        ifc.note_pressed  = p;
        ifc.note_released = r;
        ifc.note          = n;
        ifc.velocity      = v;
        ifc.channel       = c;
        tick();
        ifc.note_pressed  = 1'b0;
        ifc.note_released = 1'b0;
    endtask

    task automatic apply_reset();
        nreset = 1'b0;
        tick();
        tick();
        nreset = 1'b1;
        tick();
    endtask

    function automatic logic [6:0] vnote(input int i);
        return ifc.voice_note[7*i +: 7];
    endfunction

    function automatic logic [6:0] vvel(input int i);
        return ifc.voice_vel[7*i +: 7];
    endfunction

    function automatic logic [3:0] vchan(input int i);
        return ifc.voice_chan[4*i +: 4];
    endfunction

    initial begin
        n_vec = 0;
        n_bad = 0;
        nreset = 1'b0;
        ifc.note_pressed  = 1'b0;
        ifc.note_released = 1'b0;
        ifc.note          = 7'd0;
        ifc.velocity      = 7'd0;
        ifc.channel       = 4'd0;
        ifc.voice_active  = 8'h00;
        tick();
        tick();
        chk_eq("rst_gate",  ifc.voice_gate,  8'h00);
        chk_eq("rst_start", ifc.voice_start, 8'h00);
        chk_eq("rst_note",  ifc.voice_note,  56'd0);
        chk_eq("rst_busy",  ifc.busy,        1'b0);
        chk_eq("rst_drop",  ifc.ev_drop,     8'd0);
        chk_eq("rst_steal", ifc.steal_cnt,   8'd0);
        nreset = 1'b1;
        tick();

        // 1: first press lands on voice 0 exactly 10 edges after capture
        send(1'b1, 1'b0, 7'd60, 7'd100, 4'd0);
        chk_eq("t1_busy", ifc.busy, 1'b1);
        repeat (9) tick();
        chk_eq("t1_early_gate", ifc.voice_gate, 8'h00);
        tick();
        chk_eq("t1_gate",  ifc.voice_gate,  8'h01);
        chk_eq("t1_note0", vnote(0),        7'd60);
        chk_eq("t1_vel0",  vvel(0),         7'd100);
        chk_eq("t1_chan0", vchan(0),        4'd0);
        chk_eq("t1_start", ifc.voice_start, 8'h01);
        chk_eq("t1_idle",  ifc.busy,        1'b0);
        tick();
        chk_eq("t1_start_end", ifc.voice_start, 8'h00);

        // 2: unmatched release changes nothing, matched release gates off
        send(1'b0, 1'b1, 7'd61, 7'd0, 4'd0);
        repeat (10) tick();
        chk_eq("t2_nomatch_gate", ifc.voice_gate, 8'h01);
        chk_eq("t2_nomatch_stop", ifc.voice_stop, 8'h00);
        chk_eq("t2_nomatch_cnt",  ifc.steal_cnt,  8'd0);
        send(1'b0, 1'b1, 7'd60, 7'd0, 4'd0);
        repeat (10) tick();
        chk_eq("t2_gate",  ifc.voice_gate, 8'h00);
        chk_eq("t2_stop",  ifc.voice_stop, 8'h01);
        chk_eq("t2_note0", vnote(0),       7'd60);
        chk_eq("t2_vel0",  vvel(0),        7'd100);
        tick();
        chk_eq("t2_stop_end", ifc.voice_stop, 8'h00);

        // 3: velocity-0 press acts as release; retrigger keeps the same voice
        send(1'b1, 1'b0, 7'd60, 7'd100, 4'd0);
        repeat (10) tick();
        chk_eq("t3_gate_on", ifc.voice_gate, 8'h01);
        send(1'b1, 1'b0, 7'd60, 7'd0, 4'd0);
        repeat (10) tick();
        chk_eq("t3_gate_off", ifc.voice_gate, 8'h00);
        chk_eq("t3_stop",     ifc.voice_stop, 8'h01);
        chk_eq("t3_note0",    vnote(0),       7'd60);
        send(1'b1, 1'b0, 7'd70, 7'd55, 4'd3);
        repeat (10) tick();
        chk_eq("t3_ch_gate", ifc.voice_gate, 8'h01);
        chk_eq("t3_ch_chan", vchan(0),       4'd3);
        chk_eq("t3_ch_vel",  vvel(0),        7'd55);
        send(1'b1, 1'b0, 7'd70, 7'd90, 4'd3);
        repeat (10) tick();
        chk_eq("t3_retrig_gate",  ifc.voice_gate,  8'h01);
        chk_eq("t3_retrig_vel",   vvel(0),         7'd90);
        chk_eq("t3_retrig_start", ifc.voice_start, 8'h01);
        send(1'b0, 1'b1, 7'd70, 7'd0, 4'd0);
        repeat (10) tick();
        chk_eq("t3_wrong_chan", ifc.voice_gate, 8'h01);
        send(1'b0, 1'b1, 7'd70, 7'd0, 4'd3);
        repeat (10) tick();
        chk_eq("t3_rel_chan", ifc.voice_gate, 8'h00);

        // 4: all voices sounding, nine presses exhaust the bank
        apply_reset();
        ifc.voice_active = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            send(1'b1, 1'b0, 7'(60 + k), 7'd100, 4'd0);
            repeat (10) tick();
        end
        chk_eq("t4_full_gate", ifc.voice_gate, 8'hFF);
        chk_eq("t4_note0",     vnote(0),       7'd60);
        chk_eq("t4_note7",     vnote(7),       7'd67);
        chk_eq("t4_steal0",    ifc.steal_cnt,  8'd0);
        send(1'b1, 1'b0, 7'd68, 7'd100, 4'd0);
        repeat (10) tick();
        chk_eq("t4_gate9",  ifc.voice_gate, 8'hFF);
        chk_eq("t4_steal1", ifc.steal_cnt,  8'd1);
`ifdef VOICE_STEAL_EN
        chk_eq("t4_note9",  vnote(0),        7'd68);
        chk_eq("t4_start9", ifc.voice_start, 8'h01);
        chk_eq("t4_stop9",  ifc.voice_stop,  8'h01);
`else
        chk_eq("t4_note9",  vnote(0),        7'd60);
        chk_eq("t4_start9", ifc.voice_start, 8'h00);
        chk_eq("t4_stop9",  ifc.voice_stop,  8'h00);
`endif
        ifc.voice_active = 8'h00;

        // 5: six back-to-back strobes, one pops, four queue, one is lost
        apply_reset();
        for (int k = 0; k < 6; k++) send(1'b1, 1'b0, 7'(40 + k), 7'd64, 4'd0);
        chk_eq("t5_drop", ifc.ev_drop, 8'd1);
        chk_eq("t5_busy", ifc.busy,    1'b1);
        repeat (44) tick();
        chk_eq("t5_busy_before", ifc.busy,       1'b1);
        chk_eq("t5_gate_before", ifc.voice_gate, 8'h0F);
        tick();
        chk_eq("t5_busy_after", ifc.busy,       1'b0);
        chk_eq("t5_gate_after", ifc.voice_gate, 8'h1F);
        chk_eq("t5_note4",      vnote(4),       7'd44);
        send(1'b1, 1'b1, 7'd50, 7'd10, 4'd2);
        chk_eq("t5_both_drop", ifc.ev_drop, 8'd2);
        repeat (10) tick();
        chk_eq("t5_both_gate", ifc.voice_gate, 8'h3F);
        chk_eq("t5_both_note", vnote(5),       7'd50);
        chk_eq("t5_both_chan", vchan(5),       4'd2);

        // 6: reset asserted mid-scan clears everything with no partial commit
        send(1'b1, 1'b0, 7'd20, 7'd30, 4'd1);
        repeat (3) tick();
        nreset = 1'b0;
        #1;
        chk_eq("t6_gate", ifc.voice_gate, 8'h00);
        chk_eq("t6_note", ifc.voice_note, 56'd0);
        chk_eq("t6_busy", ifc.busy,       1'b0);
        chk_eq("t6_drop", ifc.ev_drop,    8'd0);
        #2;
        nreset = 1'b1;
        repeat (12) tick();
        chk_eq("t6_post_gate",  ifc.voice_gate,  8'h00);
        chk_eq("t6_post_busy",  ifc.busy,        1'b0);
        chk_eq("t6_post_start", ifc.voice_start, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
